// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream handshake plus instruction-memory write port
interface program_loader_if;
  logic in_valid;
  logic [7:0] in_data;
  logic in_ready;
  logic imem_WriteEnable;
  logic [31:0] imem_Address;
  logic [31:0] imem_WriteData;
  modport master (
    output in_valid, in_data,
    input in_ready, imem_WriteEnable, imem_Address, imem_WriteData
  );
  modport slave (
    input in_valid, in_data,
    output in_ready, imem_WriteEnable, imem_Address, imem_WriteData
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: assembles a checksummed byte stream into instruction memory, holding the CPU in reset until it loads cleanly
module program_loader #(
  parameter int INSTR_MEM_SIZE = 1024
) (
  input  logic clock,
  input  logic reset,
  program_loader_if.slave bus,
  output logic cpu_reset,
  output logic done,
  output logic error
);
  localparam int IW = $clog2(INSTR_MEM_SIZE) + 1;
  typedef enum logic [2:0] {HEADER, DATA, CHECK, DONE, ERROR} state_t;
  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [31:0] n, n_n, word;
  logic [23:0] sh, sh_n;
  logic [7:0] xacc, xacc_n;
  logic fire, we_n;
  assign fire = bus.in_valid && bus.in_ready;
  assign word = {sh, bus.in_data};
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    n_n = n;
    sh_n = sh;
    xacc_n = xacc;
    we_n = 1'b0;
    if (fire) begin
      cnt_n = cnt + 2'd1;
      sh_n = word[23:0];
      case (state)
        HEADER: if (cnt == 2'd3) begin
          n_n = word;
          idx_n = '0;
          xacc_n = '0;
          // full 32-bit compare so huge counts cannot wrap into range
          state_n = (word > 32'(INSTR_MEM_SIZE)) ? ERROR : (word == 32'd0) ? CHECK : DATA;
        end
        DATA: begin
          xacc_n = xacc ^ bus.in_data;
          if (cnt == 2'd3) begin
            we_n = 1'b1;
            idx_n = idx + IW'(1);
            if (32'(idx) + 32'd1 == n) state_n = CHECK;
          end
        end
        CHECK: state_n = (bus.in_data == xacc) ? DONE : ERROR;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= HEADER;
      cnt <= '0;
      idx <= '0;
      n <= '0;
      sh <= '0;
      xacc <= '0;
      bus.in_ready <= 1'b1;
      bus.imem_WriteEnable <= 1'b0;
      bus.imem_Address <= '0;
      bus.imem_WriteData <= '0;
      cpu_reset <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      n <= n_n;
      sh <= sh_n;
      xacc <= xacc_n;
      bus.imem_WriteEnable <= we_n;
      if (we_n) begin
        bus.imem_Address <= 32'({idx, 2'b00});
        bus.imem_WriteData <= word;
      end
      bus.in_ready <= (state_n == HEADER) || (state_n == DATA) || (state_n == CHECK);
      cpu_reset <= state_n != DONE;
      done <= state_n == DONE;
      error <= state_n == ERROR;
    end
  end
endmodule
